game_state_sequencer: RTL and testbench
=======================================

Name: game_state_sequencer

Overview:
Generation sequencer for the falling-sand pipeline, parametrised in frame geometry, data width, RAM read latency and tick width. Each generation runs the same way. It starts the cell engine, waits for it to finish and for the frame period to expire, then streams the next-state RAM into VRAM. New over the prior controller: run/pause, single-step, VRAM clear, latency-compensated copy, generation counter, and draw gating while paused.

Parameters:
ACTIVE_COLUMNS, 640, pixels per row
ACTIVE_ROWS, 480, rows per frame
ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
DATA_WIDTH, 2, bits per cell
RD_LATENCY, 1, next-state RAM read latency in cycles (legal 1..4)
TICK_WIDTH, 27, frame period counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
frame_period_i  in  TICK_WIDTH  minimum cycles from sim_start_o to copy start
run_i  in  1  1 = free-running generations
step_i  in  1  pulse: request one generation
clear_i  in  1  pulse: request VRAM clear
draw_en_i  in  1  user draw request
sim_done_i  in  1  cell engine finished (pulse)
ram_rd_data_i  in  DATA_WIDTH  next-state RAM read data
sim_start_o  out  1  one-cycle start pulse to cell engine
ram_rd_address_o  out  ADDR_WIDTH  next-state RAM read address
vram_wr_address_o  out  ADDR_WIDTH  VRAM write address
vram_wr_data_o  out  DATA_WIDTH  VRAM write data
vram_wr_en_o  out  1  VRAM write strobe
draw_en_o  out  1  gated draw enable
busy_o  out  1  state != IDLE
generation_o  out  16  completed generations, wraps at 65535->0

Behaviour:
- N = ACTIVE_COLUMNS*ACTIVE_ROWS.
- Reset:
  - State IDLE; step/clear pending flags cleared.
  - Tick counter 0; generation_o 0.
  - All outputs 0.
  - Reset during any state aborts that state immediately. No partial-copy completion.
- Request latching:
  - step_i and clear_i set sticky pending flags in any state.
  - A flag is cleared only when consumed.
- IDLE:
  - If clear pending: go to CLEAR and consume the flag. Clear has priority.
  - Else if run_i or step pending: assert sim_start_o for 1 cycle, latch frame_period_i, reset the tick counter to 0, consume step pending, go to SIMULATE.
- SIMULATE:
  - Tick counter increments every cycle.
  - On sim_done_i go to WAIT.
  - sim_done_i is ignored in all other states.
- WAIT:
  - Tick counter keeps incrementing.
  - Exit to COPY on the first cycle with count >= latched period. If the engine overran the period, exit on the first WAIT cycle.
  - Counter saturates at all-ones; it never wraps.
- COPY:
  - Read address issued 0..N-1, one per cycle, starting the first COPY cycle.
  - The VRAM write pipeline delays address by exactly RD_LATENCY cycles. vram_wr_data_o = ram_rd_data_i; vram_wr_en_o=1 for exactly N consecutive cycles.
  - COPY lasts N+RD_LATENCY cycles. ram_rd_address_o holds N-1 after issue.
  - On the last write cycle: generation_o increments and the state returns to IDLE.
- CLEAR:
  - Writes 0 to VRAM addresses 0..N-1, one per cycle; vram_wr_en_o=1 for N cycles.
  - Then generation_o is set to 0 and the state returns to IDLE.
  - The next-state RAM is not touched; the next generation regenerates it from VRAM.
- Outputs outside write cycles:
  - vram_wr_en_o=0 outside COPY/CLEAR write cycles.
  - vram_wr_data_o=0 and vram_wr_address_o holds its last value.
- draw_en_o = draw_en_i when state is IDLE or WAIT, else 0. Combinational, so no VRAM write ever overlaps a draw.
- Mode changes:
  - run_i dropping mid-generation lets that generation complete, then the block stays in IDLE.
  - step_i while run_i=1 is latched and causes no extra generation beyond consumption at the next IDLE exit.
- Mid-operation requests:
  - clear_i during SIMULATE/WAIT/COPY completes the current generation first, then CLEAR.
  - Simultaneous clear and step pending: CLEAR, then the step generation.
- frame_period_i changes take effect only at the next sim_start_o.

Test Plan:
Bench parameters: ACTIVE_COLUMNS=4, ACTIVE_ROWS=2 (N=8), RD_LATENCY=2.
1. run_i=1, period=20, sim_done_i 5 cycles after sim_start_o, RAM data=addr[1:0] -> COPY starts at tick 20; writes addr 0..7 with data 0,1,2,3,0,1,2,3; first wr_en 2 cycles after rd addr 0; 8 strobes; generation_o=1.
2. period=20, sim_done_i at tick 30 -> one WAIT cycle, COPY starts the next cycle; period changed to 50 mid-WAIT -> affects only the next generation.
3. run_i=0, step_i pulse during reset release plus 3 cycles -> exactly one sim_start_o, one copy; back in IDLE, busy_o=0, generation_o=1; no further starts for 100 cycles.
4. clear_i pulsed in COPY at write 3 -> remaining 5 copy writes complete, then 8 writes of 0 to addr 0..7; generation_o=0.
5. draw_en_i held 1 -> draw_en_o 0 in SIMULATE/COPY/CLEAR, 1 in WAIT/IDLE.
6. reset_i asserted at COPY write 4 -> next cycle vram_wr_en_o=0, busy_o=0, generation_o=0, sim_start_o=0, pending flags clear.

Source files
------------

// File: rtl/game_state_sequencer.sv
// Purpose: per-generation sequencer: start cell engine, enforce frame period, copy next-state RAM into VRAM, clear VRAM on request.
// Latency: sim_start_o one cycle after an IDLE exit decision; VRAM writes trail read addresses by RD_LATENCY cycles.
// Backpressure: none; step/clear requests are held as sticky flags until IDLE consumes them, draw is gated off while VRAM is written.
module game_state_sequencer #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 2,
    parameter int RD_LATENCY     = 1,
    parameter int TICK_WIDTH     = 27
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [TICK_WIDTH-1:0] frame_period_i,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic                  clear_i,
    input  logic                  draw_en_i,
    input  logic                  sim_done_i,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic                  sim_start_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
    output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
    output logic [DATA_WIDTH-1:0] vram_wr_data_o,
    output logic                  vram_wr_en_o,
    output logic                  draw_en_o,
    output logic                  busy_o,
    output logic [15:0]           generation_o
);

    localparam int N     = ACTIVE_COLUMNS * ACTIVE_ROWS;
    // Phase counter must reach N+RD_LATENCY-1 (end of COPY drain).
    localparam int CNT_W = $clog2(N + RD_LATENCY + 1);

    localparam logic [CNT_W-1:0]      COPY_LAST  = CNT_W'(N + RD_LATENCY - 1);
    localparam logic [CNT_W-1:0]      CLEAR_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]      ISSUE_END  = CNT_W'(N);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIMULATE,
        ST_WAIT,
        ST_COPY,
        ST_CLEAR
    } state_t;

    state_t                  state_q, state_d;
    logic                    step_pend_q, step_pend_d;
    logic                    clear_pend_q, clear_pend_d;
    logic [TICK_WIDTH-1:0]   tick_q, tick_d;
    logic [TICK_WIDTH-1:0]   period_q, period_d;
    logic [15:0]             gen_q, gen_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_last_q, wr_addr_last_d;
    logic                    sim_start_q, sim_start_d;

    // Read-latency compensation: valid bit and address travel together.
    logic [RD_LATENCY-1:0]                 pipe_vld_q;
    logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr_q;

    logic                    issue_vld;
    logic                    copy_wr;
    logic                    clear_wr;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr_cur;
    logic [TICK_WIDTH-1:0]   tick_inc;
    logic [TICK_WIDTH:0]     tick_plus1;
    logic                    tick_reach;

    // Saturating tick increment and the "next cycle reaches the period" test.
    // tick_q equals the number of cycles since the sim_start_o cycle, so
    // leaving WAIT when tick_q+1 >= period puts the first COPY cycle exactly
    // frame_period cycles after sim_start_o (or immediately on an overrun).
    always_comb begin
        tick_inc   = (&tick_q) ? tick_q : tick_q + TICK_WIDTH'(1);
        tick_plus1 = {1'b0, tick_q} + (TICK_WIDTH + 1)'(1);
        tick_reach = (tick_plus1 >= {1'b0, period_q});
    end

    // Write-side decode: copy writes come out of the latency pipe, clear writes follow the phase counter.
    always_comb begin
        issue_vld   = (state_q == ST_COPY) && (cnt_q < ISSUE_END);
        copy_wr     = (state_q == ST_COPY) && pipe_vld_q[RD_LATENCY-1];
        clear_wr    = (state_q == ST_CLEAR);
        wr_en       = copy_wr || clear_wr;
        wr_addr_cur = copy_wr ? pipe_addr_q[RD_LATENCY-1] : ADDR_WIDTH'(cnt_q);
    end

    // Next-state logic for the generation FSM and its bookkeeping registers.
    always_comb begin
        state_d        = state_q;
        step_pend_d    = step_pend_q | step_i;
        clear_pend_d   = clear_pend_q | clear_i;
        tick_d         = tick_q;
        period_d       = period_q;
        gen_d          = gen_q;
        cnt_d          = cnt_q;
        rd_addr_d      = rd_addr_q;
        sim_start_d    = 1'b0;
        wr_addr_last_d = wr_en ? wr_addr_cur : wr_addr_last_q;

        case (state_q)
            ST_IDLE: begin
                if (clear_pend_q) begin
                    // Consuming the flag; a request arriving this same cycle is kept.
                    state_d      = ST_CLEAR;
                    clear_pend_d = clear_i;
                    cnt_d        = '0;
                end else if (run_i || step_pend_q) begin
                    state_d     = ST_SIMULATE;
                    sim_start_d = 1'b1;
                    period_d    = frame_period_i;
                    tick_d      = '0;
                    step_pend_d = step_i;
                end
            end
            ST_SIMULATE: begin
                tick_d = tick_inc;
                if (sim_done_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tick_d = tick_inc;
                if (tick_reach) begin
                    state_d   = ST_COPY;
                    cnt_d     = '0;
                    rd_addr_d = '0;
                end
            end
            ST_COPY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Read address parks on the last cell while the pipe drains.
                if (rd_addr_q != ADDR_LAST) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
                if (cnt_q == COPY_LAST) begin
                    state_d = ST_IDLE;
                    gen_d   = gen_q + 16'd1;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CLEAR_LAST) begin
                    state_d = ST_IDLE;
                    gen_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset abandons any copy or clear in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            step_pend_q    <= 1'b0;
            clear_pend_q   <= 1'b0;
            tick_q         <= '0;
            period_q       <= '0;
            gen_q          <= '0;
            cnt_q          <= '0;
            rd_addr_q      <= '0;
            wr_addr_last_q <= '0;
            sim_start_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_pend_q    <= step_pend_d;
            clear_pend_q   <= clear_pend_d;
            tick_q         <= tick_d;
            period_q       <= period_d;
            gen_q          <= gen_d;
            cnt_q          <= cnt_d;
            rd_addr_q      <= rd_addr_d;
            wr_addr_last_q <= wr_addr_last_d;
            sim_start_q    <= sim_start_d;
        end
    end

    // Delay line matching the next-state RAM read latency.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pipe_vld_q  <= '0;
            pipe_addr_q <= '0;
        end else begin
            pipe_vld_q[0]  <= issue_vld;
            pipe_addr_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    // Output drive: write port idles at data 0 holding the last address; draw only when VRAM is quiet.
    always_comb begin
        sim_start_o       = sim_start_q;
        ram_rd_address_o  = rd_addr_q;
        vram_wr_en_o      = wr_en;
        vram_wr_address_o = wr_en ? wr_addr_cur : wr_addr_last_q;
        vram_wr_data_o    = copy_wr ? ram_rd_data_i : '0;
        draw_en_o         = draw_en_i && !reset_i &&
                            ((state_q == ST_IDLE) || (state_q == ST_WAIT));
        busy_o            = (state_q != ST_IDLE);
        generation_o      = gen_q;
    end

endmodule

// File: tb/tb_game_state_sequencer.sv
// Purpose: directed bench for game_state_sequencer with a 4x2 frame and 2-cycle RAM latency.
// Latency: outputs sampled on the falling edge; inputs driven on the falling edge for the next rising edge.
// Backpressure: not applicable; the engine responder pulses sim_done_i a programmable delay after each start.
module tb_game_state_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [26:0] frame_period_i;
    logic        run_i;
    logic        step_i;
    logic        clear_i;
    logic        draw_en_i;
    logic        sim_done_i;
    logic [1:0]  ram_rd_data_i;
    logic        sim_start_o;
    logic [2:0]  ram_rd_address_o;
    logic [2:0]  vram_wr_address_o;
    logic [1:0]  vram_wr_data_o;
    logic        vram_wr_en_o;
    logic        draw_en_o;
    logic        busy_o;
    logic [15:0] generation_o;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;
    int since_start = -1;
    int done_delay  = 5;

    logic [2:0] ram_p1 = '0;
    logic [2:0] ram_p2 = '0;

    game_state_sequencer #(
        .ACTIVE_COLUMNS(4),
        .ACTIVE_ROWS   (2),
        .ADDR_WIDTH    (3),
        .DATA_WIDTH    (2),
        .RD_LATENCY    (2),
        .TICK_WIDTH    (27)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .frame_period_i   (frame_period_i),
        .run_i            (run_i),
        .step_i           (step_i),
        .clear_i          (clear_i),
        .draw_en_i        (draw_en_i),
        .sim_done_i       (sim_done_i),
        .ram_rd_data_i    (ram_rd_data_i),
        .sim_start_o      (sim_start_o),
        .ram_rd_address_o (ram_rd_address_o),
        .vram_wr_address_o(vram_wr_address_o),
        .vram_wr_data_o   (vram_wr_data_o),
        .vram_wr_en_o     (vram_wr_en_o),
        .draw_en_o        (draw_en_o),
        .busy_o           (busy_o),
        .generation_o     (generation_o)
    );

    always #5 clk_i = ~clk_i;

    // Next-state RAM model: two-cycle read latency, contents = address[1:0].
    always @(posedge clk_i) begin
        ram_p1 <= ram_rd_address_o;
        ram_p2 <= ram_p1;
    end
    assign ram_rd_data_i = ram_p2[1:0];

    // Cell engine model: sim_done_i pulses done_delay cycles after each start; also counts starts.
    always @(negedge clk_i) begin
        if (sim_start_o) begin
            since_start = 0;
            starts      = starts + 1;
        end else if (since_start >= 0) begin
            since_start = since_start + 1;
        end
        sim_done_i = (since_start == done_delay);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk_i);
    endtask

    // One full generation starting at the sim_start_o cycle (k=0) through the IDLE cycle after COPY.
    // cs: first COPY cycle; d: sim_done cycle; act 1 = period->50, 3 = clear pulse, at cycle act_k.
    task automatic run_gen(input string nm, input int cs, input int d, input int prev_rd,
                           input int prev_wr, input int gen, input int act_k, input int act);
        for (int k = 0; k <= cs + 10; k++) begin
            int exp_rd;
            int exp_wa;
            int exp_wd;
            bit exp_wr;
            bit exp_draw;
            exp_rd   = (k < cs) ? prev_rd : ((k - cs > 7) ? 7 : k - cs);
            exp_wr   = (k >= cs + 2) && (k <= cs + 9);
            exp_wa   = exp_wr ? (k - cs - 2) : ((k < cs + 2) ? prev_wr : 7);
            exp_wd   = exp_wr ? ((k - cs - 2) % 4) : 0;
            exp_draw = ((k > d) && (k < cs)) || (k == cs + 10);
            check($sformatf("%s_start@%0d", nm, k), 32'(sim_start_o), 32'(k == 0));
            check($sformatf("%s_busy@%0d", nm, k), 32'(busy_o), 32'(k < cs + 10));
            check($sformatf("%s_draw@%0d", nm, k), 32'(draw_en_o), 32'(exp_draw));
            check($sformatf("%s_rd@%0d", nm, k), 32'(ram_rd_address_o), 32'(exp_rd));
            check($sformatf("%s_wren@%0d", nm, k), 32'(vram_wr_en_o), 32'(exp_wr));
            check($sformatf("%s_wa@%0d", nm, k), 32'(vram_wr_address_o), 32'(exp_wa));
            check($sformatf("%s_wd@%0d", nm, k), 32'(vram_wr_data_o), 32'(exp_wd));
            check($sformatf("%s_gen@%0d", nm, k), 32'(generation_o),
                  32'((k < cs + 10) ? gen - 1 : gen));
            clear_i = 1'b0;
            if (k == act_k && act == 1) frame_period_i = 27'd50;
            if (k == act_k && act == 3) clear_i = 1'b1;
            nxt();
        end
        clear_i = 1'b0;
    endtask

    // CLEAR phase from its first cycle through the following IDLE cycle.
    task automatic clear_window(input string nm, input int gen_before);
        for (int j = 0; j <= 8; j++) begin
            check($sformatf("%s_wren@%0d", nm, j), 32'(vram_wr_en_o), 32'(j < 8));
            check($sformatf("%s_wa@%0d", nm, j), 32'(vram_wr_address_o), 32'((j < 8) ? j : 7));
            check($sformatf("%s_wd@%0d", nm, j), 32'(vram_wr_data_o), 32'(0));
            check($sformatf("%s_draw@%0d", nm, j), 32'(draw_en_o), 32'(j == 8));
            check($sformatf("%s_busy@%0d", nm, j), 32'(busy_o), 32'(j < 8));
            check($sformatf("%s_gen@%0d", nm, j), 32'(generation_o),
                  32'((j < 8) ? gen_before : 0));
            nxt();
        end
    endtask

    initial begin
        reset_i        = 1'b1;
        frame_period_i = 27'd20;
        run_i          = 1'b0;
        step_i         = 1'b0;
        clear_i        = 1'b0;
        draw_en_i      = 1'b1;
        sim_done_i     = 1'b0;

        // Reset state
        nxt(); nxt(); nxt();
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_gen", 32'(generation_o), 32'(0));
        check("rst_start", 32'(sim_start_o), 32'(0));
        check("rst_wren", 32'(vram_wr_en_o), 32'(0));
        check("rst_rd", 32'(ram_rd_address_o), 32'(0));
        check("rst_wa", 32'(vram_wr_address_o), 32'(0));
        check("rst_wd", 32'(vram_wr_data_o), 32'(0));
        check("rst_draw", 32'(draw_en_o), 32'(0));

        // Free run, period 20, engine done at tick 5
        reset_i = 1'b0;
        run_i   = 1'b1;
        nxt();
        run_gen("g1", 20, 5, 0, 0, 1, -1, 0);

        // Engine overruns (done at tick 30); period changed to 50 during WAIT
        done_delay = 30;
        run_gen("g2", 32, 30, 7, 7, 2, 31, 1);

        // Period 50 now in force; run dropped mid-generation; clear at copy write 3
        done_delay = 5;
        run_i      = 1'b0;
        run_gen("g3", 50, 5, 7, 7, 3, 55, 3);
        clear_window("clr1", 3);
        for (int i = 0; i < 20; i++) nxt();
        check("idle1_busy", 32'(busy_o), 32'(0));
        check("idle1_starts", 32'(starts), 32'(3));

        // Single step after reset release
        reset_i = 1'b1;
        nxt(); nxt();
        reset_i        = 1'b0;
        frame_period_i = 27'd20;
        nxt(); nxt(); nxt();
        step_i = 1'b1;
        nxt();
        step_i = 1'b0;
        check("step_wait_start", 32'(sim_start_o), 32'(0));
        check("step_wait_busy", 32'(busy_o), 32'(0));
        nxt();
        run_gen("st", 20, 5, 0, 0, 1, -1, 0);
        for (int i = 0; i < 100; i++) nxt();
        check("step_idle_busy", 32'(busy_o), 32'(0));
        check("step_idle_gen", 32'(generation_o), 32'(1));
        check("step_idle_starts", 32'(starts), 32'(4));

        // Reset during copy write 4 with step and clear pending
        step_i = 1'b1;
        nxt();
        step_i = 1'b0;
        nxt();
        check("r6_start", 32'(sim_start_o), 32'(1));
        for (int k = 0; k < 26; k++) begin
            step_i  = (k == 10);
            clear_i = (k == 10);
            nxt();
        end
        step_i  = 1'b0;
        clear_i = 1'b0;
        check("r6_pre_wren", 32'(vram_wr_en_o), 32'(1));
        check("r6_pre_wa", 32'(vram_wr_address_o), 32'(4));
        check("r6_pre_gen", 32'(generation_o), 32'(1));
        reset_i = 1'b1;
        nxt();
        check("r6_wren", 32'(vram_wr_en_o), 32'(0));
        check("r6_busy", 32'(busy_o), 32'(0));
        check("r6_gen", 32'(generation_o), 32'(0));
        check("r6_start0", 32'(sim_start_o), 32'(0));
        check("r6_rd", 32'(ram_rd_address_o), 32'(0));
        check("r6_wa", 32'(vram_wr_address_o), 32'(0));
        reset_i = 1'b0;
        for (int i = 0; i < 6; i++) nxt();
        check("r6_after_busy", 32'(busy_o), 32'(0));
        check("r6_after_wren", 32'(vram_wr_en_o), 32'(0));
        check("r6_after_starts", 32'(starts), 32'(5));

        // Clear and step requested together: clear first, then one generation
        clear_i = 1'b1;
        step_i  = 1'b1;
        nxt();
        clear_i = 1'b0;
        step_i  = 1'b0;
        check("cs_idle_busy", 32'(busy_o), 32'(0));
        nxt();
        clear_window("clr2", 0);
        run_gen("cs", 20, 5, 0, 7, 1, -1, 0);
        for (int i = 0; i < 10; i++) nxt();
        check("cs_final_starts", 32'(starts), 32'(6));
        check("cs_final_busy", 32'(busy_o), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
